iob_axi_rd2iob: RTL and testbench
=================================

IOB_AXI_RD2IOB -- requirements
Module: iob_axi_rd2iob

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, address width of both buses; DATA_W, 32, data width of both buses; AXI_ID_W, 1, ID width; AXI_LEN_W, 8, burst length width.
REQ-002 SHALL use one clock, clk_i; reset is asynchronous and active-low, arst_n_i.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
- clk_i  in  1  clock
- arst_n_i  in  1  async active-low reset
- cke_i  in  1  clock enable; low freezes all registers
- axi_araddr_i  in  ADDR_W  burst start address
- axi_arvalid_i  in  1  AR valid
- axi_arready_o  out  1  AR ready
- axi_arid_i  in  AXI_ID_W  transaction ID
- axi_arlen_i  in  AXI_LEN_W  beats minus one
- axi_arburst_i  in  2  burst type
- axi_rdata_o  out  DATA_W  read data
- axi_rresp_o  out  2  response
- axi_rvalid_o  out  1  R valid
- axi_rready_i  in  1  R ready
- axi_rid_o  out  AXI_ID_W  echoed ID
- axi_rlast_o  out  1  last beat
- iob_valid_o  out  1  IOb request
- iob_addr_o  out  ADDR_W  IOb address
- iob_wdata_o  out  DATA_W  tied 0
- iob_wstrb_o  out  DATA_W/8  tied 0 (read only)
- iob_rvalid_i  in  1  IOb read data valid
- iob_rdata_i  in  DATA_W  IOb read data
- iob_ready_i  in  1  IOb request accepted

Function
REQ-004 SHALL be an AXI4 read-only subordinate converting each burst into sequential single-word IOb manager reads; one burst outstanding.
REQ-005 SHALL implement states IDLE, RD_REQ, RD_WAIT, RD_DATA; axi_arready_o=1 only in IDLE.
REQ-006 IDLE, arvalid&arready: latch araddr, arid, arlen, arburst; beat counter=0; go RD_REQ if arburst is 00 (FIXED) or 01 (INCR), else RD_DATA in error mode.
REQ-007 RD_REQ: iob_valid_o=1, iob_addr_o=current address; hold until iob_ready_i, then RD_WAIT; valid never withdrawn before ready.
REQ-008 RD_WAIT: on iob_rvalid_i register iob_rdata_i, go RD_DATA; iob_rvalid_i outside RD_WAIT ignored.
REQ-009 RD_DATA: axi_rvalid_o=1, rdata=registered word, rid=latched ID, rresp=00, rlast=(counter==latched len); all R outputs stable while rvalid&!rready.
REQ-010 RD_DATA with rready: rlast -> IDLE; else counter+1, address update, -> RD_REQ.
REQ-011 Address update: INCR adds DATA_W/8 modulo 2^ADDR_W (wraps silently at top); FIXED keeps address; low bits passed unaligned.
REQ-012 Error mode (arburst 10/11): no IOb request issued; len+1 beats with rresp=10 (SLVERR), rdata=0, correct rlast and rid.
REQ-013 Latency: AR handshake cycle N -> iob_valid_o cycle N+1; iob_rvalid_i cycle M -> axi_rvalid_o cycle M+1; rready cycle K -> next iob_valid_o cycle K+1.
REQ-014 arlen = 2^AXI_LEN_W-1 SHALL yield 2^AXI_LEN_W beats; counter width AXI_LEN_W, no overflow.
REQ-015 cke_i low SHALL hold state, counter, address and registered data; outputs keep values.

Reset
REQ-016 While arst_n_i low: state IDLE, all outputs 0 (including axi_arready_o), counter/address/ID/data registers 0.
REQ-017 axi_arready_o SHALL rise first clk_i edge after arst_n_i deasserts with cke_i high.
REQ-018 Reset mid-burst SHALL abort immediately; no further IOb requests or R beats of that burst.

Verification
REQ-019 INCR arlen=3 addr 0x100, IOb ready/rvalid immediate -> IOb addrs 0x100,0x104,0x108,0x10C; 4 R beats, rlast on 4th only, rresp 00, rid echoed.
REQ-020 FIXED arlen=2 addr 0x40 -> three IOb reads all at 0x40.
REQ-021 WRAP arburst=10 arlen=1 -> zero iob_valid_o cycles, 2 beats rresp=10 rdata=0, rlast on 2nd.
REQ-022 INCR addr 0xFFFFFFFC arlen=1 -> second IOb addr 0x00000000.
REQ-023 iob_ready_i delayed 3 cycles, rready low 2 cycles on beat 1 -> iob_valid_o held, R outputs stable, data matches memory model.
REQ-024 arst_n_i pulsed low during beat 2 of arlen=7 -> all outputs 0, arready_o=1 next cycle after release, new burst completes correctly.

Source files
------------

// File: rtl/iob_axi_rd2iob_if.sv
// Signal bundle between an AXI4 read-only manager, the AXI-to-IOb read bridge
// and the IOb subordinate it feeds. Names are seen from the bridge's side.
interface iob_axi_rd2iob_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_ID_W  = 1,
  parameter int AXI_LEN_W = 8
);
  logic [ADDR_W-1:0]    axi_araddr_i;
  logic                 axi_arvalid_i;
  logic                 axi_arready_o;
  logic [AXI_ID_W-1:0]  axi_arid_i;
  logic [AXI_LEN_W-1:0] axi_arlen_i;
  logic [1:0]           axi_arburst_i;
  logic [DATA_W-1:0]    axi_rdata_o;
  logic [1:0]           axi_rresp_o;
  logic                 axi_rvalid_o;
  logic                 axi_rready_i;
  logic [AXI_ID_W-1:0]  axi_rid_o;
  logic                 axi_rlast_o;
  logic                 iob_valid_o;
  logic [ADDR_W-1:0]    iob_addr_o;
  logic [DATA_W-1:0]    iob_wdata_o;
  logic [DATA_W/8-1:0]  iob_wstrb_o;
  logic                 iob_rvalid_i;
  logic [DATA_W-1:0]    iob_rdata_i;
  logic                 iob_ready_i;

  // Bridge side: AXI subordinate and IOb manager
  modport slave (
    input  axi_araddr_i, axi_arvalid_i, axi_arid_i, axi_arlen_i, axi_arburst_i,
    input  axi_rready_i, iob_rvalid_i, iob_rdata_i, iob_ready_i,
    output axi_arready_o, axi_rdata_o, axi_rresp_o, axi_rvalid_o, axi_rid_o,
    output axi_rlast_o, iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o
  );

  // Environment side: AXI manager and IOb memory
  modport master (
    output axi_araddr_i, axi_arvalid_i, axi_arid_i, axi_arlen_i, axi_arburst_i,
    output axi_rready_i, iob_rvalid_i, iob_rdata_i, iob_ready_i,
    input  axi_arready_o, axi_rdata_o, axi_rresp_o, axi_rvalid_o, axi_rid_o,
    input  axi_rlast_o, iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o
  );
endinterface

// File: rtl/iob_axi_rd2iob.sv
// AXI4 read-only subordinate that turns each burst into a sequence of single-word
// IOb reads. One burst in flight; unsupported burst types answer with SLVERR beats.
module iob_axi_rd2iob #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_ID_W  = 1,
  parameter int AXI_LEN_W = 8
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  iob_axi_rd2iob_if.slave   bus
);

  localparam logic [ADDR_W-1:0] ADDR_STEP   = ADDR_W'(DATA_W / 8);
  localparam logic [1:0]        BURST_FIXED = 2'b00;
  localparam logic [1:0]        BURST_INCR  = 2'b01;
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_REQ  = 2'b01,
    RD_WAIT = 2'b10,
    RD_DATA = 2'b11
  } state_t;

  state_t               state_r;
  logic [ADDR_W-1:0]    addr_r;
  logic [AXI_ID_W-1:0]  id_r;
  logic [AXI_LEN_W-1:0] len_r;
  logic [AXI_LEN_W-1:0] cnt_r;
  logic                 incr_r;
  logic                 err_r;
  logic                 arready_r;
  logic                 iob_valid_r;
  logic                 rvalid_r;
  logic                 rlast_r;
  logic [DATA_W-1:0]    rdata_r;
  logic [1:0]           rresp_r;

  logic [AXI_LEN_W-1:0] cnt_nxt_s;
  logic                 ar_hs_s;
  logic                 ar_ok_s;

  assign cnt_nxt_s = cnt_r + AXI_LEN_W'(1'b1);
  assign ar_hs_s   = arready_r & bus.axi_arvalid_i;
  assign ar_ok_s   = (bus.axi_arburst_i == BURST_FIXED) || (bus.axi_arburst_i == BURST_INCR);

  assign bus.axi_arready_o = arready_r;
  assign bus.axi_rdata_o   = rdata_r;
  assign bus.axi_rresp_o   = rresp_r;
  assign bus.axi_rvalid_o  = rvalid_r;
  assign bus.axi_rid_o     = id_r;
  assign bus.axi_rlast_o   = rlast_r;
  assign bus.iob_valid_o   = iob_valid_r;
  assign bus.iob_addr_o    = addr_r;
  assign bus.iob_wdata_o   = {DATA_W{1'b0}};
  assign bus.iob_wstrb_o   = {(DATA_W/8){1'b0}};

  // Burst sequencer; every output is a register so all handshakes start one cycle after their cause
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      id_r        <= {AXI_ID_W{1'b0}};
      len_r       <= {AXI_LEN_W{1'b0}};
      cnt_r       <= {AXI_LEN_W{1'b0}};
      incr_r      <= 1'b0;
      err_r       <= 1'b0;
      arready_r   <= 1'b0;
      iob_valid_r <= 1'b0;
      rvalid_r    <= 1'b0;
      rlast_r     <= 1'b0;
      rdata_r     <= {DATA_W{1'b0}};
      rresp_r     <= RESP_OKAY;
    end else if (cke_i) begin
      case (state_r)
        IDLE: begin
          if (ar_hs_s) begin
            arready_r <= 1'b0;
            addr_r    <= bus.axi_araddr_i;
            id_r      <= bus.axi_arid_i;
            len_r     <= bus.axi_arlen_i;
            incr_r    <= (bus.axi_arburst_i == BURST_INCR);
            cnt_r     <= {AXI_LEN_W{1'b0}};
            if (ar_ok_s) begin
              err_r       <= 1'b0;
              iob_valid_r <= 1'b1;
              state_r     <= RD_REQ;
            end else begin
              // Unsupported burst: no IOb traffic, stream error beats straight away
              err_r    <= 1'b1;
              rvalid_r <= 1'b1;
              rdata_r  <= {DATA_W{1'b0}};
              rresp_r  <= RESP_SLVERR;
              rlast_r  <= (bus.axi_arlen_i == {AXI_LEN_W{1'b0}});
              state_r  <= RD_DATA;
            end
          end else begin
            arready_r <= 1'b1;
          end
        end
        RD_REQ: begin
          if (bus.iob_ready_i) begin
            iob_valid_r <= 1'b0;
            state_r     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.iob_rvalid_i) begin
            rdata_r  <= bus.iob_rdata_i;
            rvalid_r <= 1'b1;
            rresp_r  <= RESP_OKAY;
            rlast_r  <= (cnt_r == len_r);
            state_r  <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.axi_rready_i) begin
            if (rlast_r) begin
              rvalid_r  <= 1'b0;
              rlast_r   <= 1'b0;
              rresp_r   <= RESP_OKAY;
              arready_r <= 1'b1;
              state_r   <= IDLE;
            end else if (err_r) begin
              cnt_r   <= cnt_nxt_s;
              rlast_r <= (cnt_nxt_s == len_r);
            end else begin
              // Address wraps silently at the top of the space
              cnt_r       <= cnt_nxt_s;
              addr_r      <= incr_r ? (addr_r + ADDR_STEP) : addr_r;
              rvalid_r    <= 1'b0;
              iob_valid_r <= 1'b1;
              state_r     <= RD_REQ;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          arready_r   <= 1'b0;
          iob_valid_r <= 1'b0;
          rvalid_r    <= 1'b0;
          rlast_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_axi_rd2iob.sv
// Directed bench for iob_axi_rd2iob: an AXI read manager driver, an IOb memory
// responder with programmable ready delay, and one task per scenario.
module tb_iob_axi_rd2iob;

  logic clk;
  logic arst_n;
  logic cke;
  int   total;
  int   bad;
  int   cyc;

  iob_axi_rd2iob_if #(.ADDR_W(32), .DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8)) bus ();

  iob_axi_rd2iob #(.ADDR_W(32), .DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .cke_i    (cke),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // IOb memory responder state
  int          ready_delay;
  int          wait_cnt;
  int          valid_cycles;
  int          hold_err;
  bit          acc_pend;
  bit          waiting;
  logic [31:0] acc_addr;
  logic [31:0] prev_addr;
  logic [31:0] addr_log[$];

  // Memory: accepts after ready_delay waiting cycles, returns data one cycle later
  initial begin
    bus.iob_ready_i  = 1'b0;
    bus.iob_rvalid_i = 1'b0;
    bus.iob_rdata_i  = 32'h0;
    acc_pend = 1'b0;
    waiting  = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (acc_pend) begin
        bus.iob_rvalid_i = 1'b1;
        bus.iob_rdata_i  = mem_word(acc_addr);
        acc_pend = 1'b0;
      end else begin
        bus.iob_rvalid_i = 1'b0;
        bus.iob_rdata_i  = 32'h0;
      end
      if (bus.iob_valid_o) begin
        valid_cycles++;
        if (waiting && bus.iob_addr_o !== prev_addr) hold_err++;
        prev_addr = bus.iob_addr_o;
        if (wait_cnt >= ready_delay) begin
          bus.iob_ready_i = 1'b1;
          acc_pend = 1'b1;
          acc_addr = bus.iob_addr_o;
          addr_log.push_back(bus.iob_addr_o);
          wait_cnt = 0;
          waiting  = 1'b0;
        end else begin
          bus.iob_ready_i = 1'b0;
          wait_cnt++;
          waiting = 1'b1;
        end
      end else begin
        if (waiting) hold_err++;
        bus.iob_ready_i = 1'b0;
        wait_cnt = 0;
        waiting  = 1'b0;
      end
    end
  end

  // R channel capture
  logic [31:0] rd_q[$];
  logic [1:0]  rs_q[$];
  logic        rl_q[$];
  logic        ri_q[$];
  int          unstable;
  int          lat_err;
  int          ar_cyc;
  bit          first_req;

  // Called at a negedge; returns at the negedge right after the AR handshake edge
  task automatic send_ar(input logic [31:0] a, input logic id, input logic [7:0] len,
                         input logic [1:0] b, output bit to);
    int budget;
    budget = 50;
    to = 1'b0;
    bus.axi_araddr_i  = a;
    bus.axi_arid_i    = id;
    bus.axi_arlen_i   = len;
    bus.axi_arburst_i = b;
    bus.axi_arvalid_i = 1'b1;
    while (!bus.axi_arready_o && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!bus.axi_arready_o) to = 1'b1;
    @(negedge clk);
    bus.axi_arvalid_i = 1'b0;
    ar_cyc    = cyc;
    first_req = bus.iob_valid_o;
  endtask

  // Called at a negedge; collects beats until rlast is accepted or the budget runs out
  task automatic collect_r(input bit is_err, input int stall_beat, input int stall_cyc,
                           input int max_cyc, output bit to);
    int          budget;
    int          beat;
    int          stall_left;
    bit          in_beat;
    bit          done;
    bit          expect_req;
    logic [31:0] cur_d;
    logic [1:0]  cur_s;
    logic        cur_l;
    logic        cur_i;
    rd_q.delete(); rs_q.delete(); rl_q.delete(); ri_q.delete();
    unstable = 0; lat_err = 0;
    budget = max_cyc; beat = 0; stall_left = 0;
    in_beat = 1'b0; done = 1'b0; expect_req = 1'b0;
    cur_d = 32'h0; cur_s = 2'b00; cur_l = 1'b0; cur_i = 1'b0;
    while (!done && budget > 0) begin
      if (expect_req) begin
        if (!bus.iob_valid_o) lat_err++;
        expect_req = 1'b0;
      end
      if (bus.axi_rvalid_o) begin
        if (!in_beat) begin
          cur_d = bus.axi_rdata_o; cur_s = bus.axi_rresp_o;
          cur_l = bus.axi_rlast_o; cur_i = bus.axi_rid_o;
          rd_q.push_back(cur_d); rs_q.push_back(cur_s);
          rl_q.push_back(cur_l); ri_q.push_back(cur_i);
          in_beat = 1'b1;
          stall_left = (beat == stall_beat) ? stall_cyc : 0;
        end else if (bus.axi_rdata_o !== cur_d || bus.axi_rresp_o !== cur_s ||
                     bus.axi_rlast_o !== cur_l || bus.axi_rid_o !== cur_i) begin
          unstable++;
        end
        if (stall_left > 0) begin
          bus.axi_rready_i = 1'b0;
          stall_left--;
        end else begin
          bus.axi_rready_i = 1'b1;
          in_beat = 1'b0;
          beat++;
          if (cur_l) done = 1'b1;
          else if (!is_err) expect_req = 1'b1;
        end
      end else begin
        bus.axi_rready_i = 1'b0;
      end
      @(negedge clk);
      budget--;
    end
    bus.axi_rready_i = 1'b0;
    to = !done;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({bus.axi_arready_o, bus.iob_valid_o, bus.axi_rvalid_o, bus.axi_rlast_o} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000",
        {bus.axi_arready_o, bus.iob_valid_o, bus.axi_rvalid_o, bus.axi_rlast_o});
    end
    total++;
    if (bus.axi_rdata_o !== 32'h0 || bus.iob_addr_o !== 32'h0) begin
      bad++; $display("FAIL reset_data: rdata %h addr %h want 0", bus.axi_rdata_o, bus.iob_addr_o);
    end
    total++;
    if ({bus.axi_rresp_o, bus.axi_rid_o} !== 3'b000 || bus.iob_wdata_o !== 32'h0 || bus.iob_wstrb_o !== 4'h0) begin
      bad++; $display("FAIL reset_misc: resp/id %b wdata %h wstrb %h want 0",
        {bus.axi_rresp_o, bus.axi_rid_o}, bus.iob_wdata_o, bus.iob_wstrb_o);
    end
    arst_n = 1'b1;
    #1;
    total++;
    if (bus.axi_arready_o !== 1'b0) begin
      bad++; $display("FAIL reset_release_arready: got %b want 0", bus.axi_arready_o);
    end
    @(negedge clk);
    total++;
    if (bus.axi_arready_o !== 1'b1) begin
      bad++; $display("FAIL reset_arready_rise: got %b want 1", bus.axi_arready_o);
    end
  endtask

  task automatic test_incr();
    bit to1, to2;
    ready_delay = 0; addr_log.delete(); valid_cycles = 0;
    send_ar(32'h100, 1'b1, 8'd3, 2'b01, to1);
    collect_r(1'b0, -1, 0, 100, to2);
    total++;
    if ({to1, to2} !== 2'b00) begin bad++; $display("FAIL incr_timeout: got %b want 00", {to1, to2}); end
    total++;
    if (first_req !== 1'b1) begin bad++; $display("FAIL incr_ar_latency: iob_valid %b want 1", first_req); end
    total++;
    if (lat_err !== 0) begin bad++; $display("FAIL incr_rready_latency: misses %0d want 0", lat_err); end
    total++;
    if (cyc - ar_cyc !== 12) begin bad++; $display("FAIL incr_duration: got %0d want 12", cyc - ar_cyc); end
    total++;
    if (addr_log.size() !== 4 || rd_q.size() !== 4) begin
      bad++; $display("FAIL incr_counts: reqs %0d beats %0d want 4 4", addr_log.size(), rd_q.size());
    end
    for (int i = 0; i < 4 && i < addr_log.size() && i < rd_q.size(); i++) begin
      total++;
      if (addr_log[i] !== 32'h100 + 32'(4 * i)) begin
        bad++; $display("FAIL incr_addr%0d: got %h want %h", i, addr_log[i], 32'h100 + 32'(4 * i));
      end
      total++;
      if (rd_q[i] !== mem_word(32'h100 + 32'(4 * i)) || rs_q[i] !== 2'b00 ||
          rl_q[i] !== (i == 3) || ri_q[i] !== 1'b1) begin
        bad++; $display("FAIL incr_beat%0d: data %h resp %b last %b id %b want %h 00 %b 1",
          i, rd_q[i], rs_q[i], rl_q[i], ri_q[i], mem_word(32'h100 + 32'(4 * i)), (i == 3));
      end
    end
  endtask

  task automatic test_fixed();
    bit to1, to2;
    ready_delay = 0; addr_log.delete();
    send_ar(32'h40, 1'b0, 8'd2, 2'b00, to1);
    collect_r(1'b0, -1, 0, 100, to2);
    total++;
    if ({to1, to2} !== 2'b00 || addr_log.size() !== 3 || rd_q.size() !== 3) begin
      bad++; $display("FAIL fixed_counts: to %b reqs %0d beats %0d want 00 3 3",
        {to1, to2}, addr_log.size(), rd_q.size());
    end
    total++;
    if (cyc - ar_cyc !== 9) begin bad++; $display("FAIL fixed_duration: got %0d want 9", cyc - ar_cyc); end
    for (int i = 0; i < 3 && i < addr_log.size() && i < rd_q.size(); i++) begin
      total++;
      if (addr_log[i] !== 32'h40 || rd_q[i] !== 32'hFFBF_0040 || rl_q[i] !== (i == 2) || ri_q[i] !== 1'b0) begin
        bad++; $display("FAIL fixed_beat%0d: addr %h data %h last %b id %b want 00000040 ffbf0040 %b 0",
          i, addr_log[i], rd_q[i], rl_q[i], ri_q[i], (i == 2));
      end
    end
  endtask

  task automatic test_wrap_err();
    bit to1, to2;
    addr_log.delete(); valid_cycles = 0;
    send_ar(32'h80, 1'b1, 8'd1, 2'b10, to1);
    collect_r(1'b1, -1, 0, 50, to2);
    total++;
    if ({to1, to2} !== 2'b00 || rd_q.size() !== 2) begin
      bad++; $display("FAIL wrap_counts: to %b beats %0d want 00 2", {to1, to2}, rd_q.size());
    end
    total++;
    if (valid_cycles !== 0) begin bad++; $display("FAIL wrap_no_iob: valid cycles %0d want 0", valid_cycles); end
    total++;
    if (cyc - ar_cyc !== 2) begin bad++; $display("FAIL wrap_duration: got %0d want 2", cyc - ar_cyc); end
    for (int i = 0; i < 2 && i < rd_q.size(); i++) begin
      total++;
      if (rd_q[i] !== 32'h0 || rs_q[i] !== 2'b10 || rl_q[i] !== (i == 1) || ri_q[i] !== 1'b1) begin
        bad++; $display("FAIL wrap_beat%0d: data %h resp %b last %b id %b want 0 10 %b 1",
          i, rd_q[i], rs_q[i], rl_q[i], ri_q[i], (i == 1));
      end
    end
    send_ar(32'h84, 1'b0, 8'd0, 2'b11, to1);
    collect_r(1'b1, -1, 0, 50, to2);
    total++;
    if ({to1, to2} !== 2'b00 || rd_q.size() !== 1 || valid_cycles !== 0) begin
      bad++; $display("FAIL rsvd_counts: to %b beats %0d valid %0d want 00 1 0",
        {to1, to2}, rd_q.size(), valid_cycles);
    end else begin
      total++;
      if (rs_q[0] !== 2'b10 || rl_q[0] !== 1'b1 || ri_q[0] !== 1'b0) begin
        bad++; $display("FAIL rsvd_beat: resp %b last %b id %b want 10 1 0", rs_q[0], rl_q[0], ri_q[0]);
      end
    end
  endtask

  task automatic test_addr_wrap();
    bit to1, to2;
    ready_delay = 0; addr_log.delete();
    send_ar(32'hFFFF_FFFC, 1'b1, 8'd1, 2'b01, to1);
    collect_r(1'b0, -1, 0, 100, to2);
    total++;
    if ({to1, to2} !== 2'b00 || addr_log.size() !== 2 || rd_q.size() !== 2) begin
      bad++; $display("FAIL awrap_counts: to %b reqs %0d beats %0d want 00 2 2",
        {to1, to2}, addr_log.size(), rd_q.size());
    end else begin
      total++;
      if (addr_log[0] !== 32'hFFFF_FFFC || addr_log[1] !== 32'h0) begin
        bad++; $display("FAIL awrap_addr: got %h %h want fffffffc 00000000", addr_log[0], addr_log[1]);
      end
      total++;
      if (rd_q[0] !== 32'h0003_FFFC || rd_q[1] !== 32'hFFFF_0000 || rl_q[1] !== 1'b1) begin
        bad++; $display("FAIL awrap_data: got %h %h last %b want 0003fffc ffff0000 1", rd_q[0], rd_q[1], rl_q[1]);
      end
    end
  endtask

  task automatic test_stall();
    bit to1, to2;
    ready_delay = 3; addr_log.delete(); valid_cycles = 0; hold_err = 0;
    send_ar(32'h300, 1'b1, 8'd2, 2'b01, to1);
    collect_r(1'b0, 1, 2, 200, to2);
    ready_delay = 0;
    total++;
    if ({to1, to2} !== 2'b00 || addr_log.size() !== 3 || rd_q.size() !== 3) begin
      bad++; $display("FAIL stall_counts: to %b reqs %0d beats %0d want 00 3 3",
        {to1, to2}, addr_log.size(), rd_q.size());
    end
    total++;
    if (valid_cycles !== 12 || hold_err !== 0) begin
      bad++; $display("FAIL stall_iob_hold: valid cycles %0d hold errs %0d want 12 0", valid_cycles, hold_err);
    end
    total++;
    if (unstable !== 0) begin bad++; $display("FAIL stall_r_stable: changes %0d want 0", unstable); end
    total++;
    if (cyc - ar_cyc !== 20) begin bad++; $display("FAIL stall_duration: got %0d want 20", cyc - ar_cyc); end
    for (int i = 0; i < 3 && i < addr_log.size() && i < rd_q.size(); i++) begin
      total++;
      if (addr_log[i] !== 32'h300 + 32'(4 * i) || rd_q[i] !== mem_word(32'h300 + 32'(4 * i)) || rl_q[i] !== (i == 2)) begin
        bad++; $display("FAIL stall_beat%0d: addr %h data %h last %b want %h %h %b", i, addr_log[i], rd_q[i],
          rl_q[i], 32'h300 + 32'(4 * i), mem_word(32'h300 + 32'(4 * i)), (i == 2));
      end
    end
  endtask

  task automatic test_cke();
    bit          to1, to2;
    int          budget;
    int          froze_bad;
    logic [31:0] snap;
    ready_delay = 0; addr_log.delete(); froze_bad = 0;
    send_ar(32'h600, 1'b0, 8'd1, 2'b01, to1);
    budget = 20;
    while (!bus.axi_rvalid_o && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    total++;
    if (bus.axi_rvalid_o !== 1'b1) begin bad++; $display("FAIL cke_first_beat: rvalid %b want 1", bus.axi_rvalid_o); end
    snap = bus.axi_rdata_o;
    cke = 1'b0;
    bus.axi_rready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.axi_rvalid_o !== 1'b1 || bus.axi_rdata_o !== snap || bus.axi_rlast_o !== 1'b0) froze_bad++;
    end
    total++;
    if (froze_bad !== 0) begin bad++; $display("FAIL cke_freeze: changed cycles %0d want 0", froze_bad); end
    bus.axi_rready_i = 1'b0;
    cke = 1'b1;
    collect_r(1'b0, -1, 0, 100, to2);
    total++;
    if ({to1, to2} !== 2'b00 || rd_q.size() !== 2 || addr_log.size() !== 2) begin
      bad++; $display("FAIL cke_counts: to %b beats %0d reqs %0d want 00 2 2",
        {to1, to2}, rd_q.size(), addr_log.size());
    end else begin
      total++;
      if (rd_q[0] !== 32'hF9FF_0600 || rd_q[1] !== 32'hF9FB_0604 || rl_q[1] !== 1'b1) begin
        bad++; $display("FAIL cke_data: got %h %h last %b want f9ff0600 f9fb0604 1", rd_q[0], rd_q[1], rl_q[1]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit   to1, to2;
    int   budget;
    int   seen;
    int   rv_seen;
    logic prev_rv;
    ready_delay = 0; addr_log.delete();
    send_ar(32'h200, 1'b1, 8'd7, 2'b01, to1);
    budget = 40; seen = 0; prev_rv = 1'b0;
    while (seen < 2 && budget > 0) begin
      if (bus.axi_rvalid_o && !prev_rv) seen++;
      prev_rv = bus.axi_rvalid_o;
      if (seen == 2) begin
        bus.axi_rready_i = 1'b0;
      end else begin
        bus.axi_rready_i = 1'b1;
        @(negedge clk);
        budget--;
      end
    end
    total++;
    if (seen !== 2) begin bad++; $display("FAIL rst_mid_reach_beat2: beats seen %0d want 2", seen); end
    arst_n = 1'b0;
    #1;
    total++;
    if ({bus.axi_arready_o, bus.iob_valid_o, bus.axi_rvalid_o, bus.axi_rlast_o} !== 4'b0000 ||
        bus.axi_rdata_o !== 32'h0 || bus.iob_addr_o !== 32'h0 || {bus.axi_rresp_o, bus.axi_rid_o} !== 3'b000) begin
      bad++; $display("FAIL rst_mid_outputs: ctrl %b rdata %h addr %h resp/id %b want 0",
        {bus.axi_arready_o, bus.iob_valid_o, bus.axi_rvalid_o, bus.axi_rlast_o},
        bus.axi_rdata_o, bus.iob_addr_o, {bus.axi_rresp_o, bus.axi_rid_o});
    end
    valid_cycles = 0; rv_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.axi_rvalid_o) rv_seen++;
    end
    arst_n = 1'b1;
    #1;
    total++;
    if (valid_cycles !== 0 || rv_seen !== 0 || bus.axi_arready_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid_quiet: iob %0d rvalid %0d arready %b want 0 0 0",
        valid_cycles, rv_seen, bus.axi_arready_o);
    end
    @(negedge clk);
    total++;
    if (bus.axi_arready_o !== 1'b1 || valid_cycles !== 0) begin
      bad++; $display("FAIL rst_mid_arready: arready %b iob %0d want 1 0", bus.axi_arready_o, valid_cycles);
    end
    addr_log.delete();
    send_ar(32'h500, 1'b0, 8'd1, 2'b01, to1);
    collect_r(1'b0, -1, 0, 100, to2);
    total++;
    if ({to1, to2} !== 2'b00 || addr_log.size() !== 2 || rd_q.size() !== 2) begin
      bad++; $display("FAIL rst_mid_new_counts: to %b reqs %0d beats %0d want 00 2 2",
        {to1, to2}, addr_log.size(), rd_q.size());
    end else begin
      total++;
      if (addr_log[0] !== 32'h500 || addr_log[1] !== 32'h504 || rd_q[1] !== 32'hFAFB_0504 ||
          rl_q[0] !== 1'b0 || rl_q[1] !== 1'b1 || ri_q[1] !== 1'b0) begin
        bad++; $display("FAIL rst_mid_new_burst: addr %h %h data1 %h last %b%b id %b want 500 504 fafb0504 01 0",
          addr_log[0], addr_log[1], rd_q[1], rl_q[0], rl_q[1], ri_q[1]);
      end
    end
  endtask

  task automatic test_max_len();
    bit to1, to2;
    int data_bad;
    int last_cnt;
    ready_delay = 0; addr_log.delete(); data_bad = 0; last_cnt = 0;
    send_ar(32'h1000, 1'b1, 8'd255, 2'b01, to1);
    collect_r(1'b0, -1, 0, 2000, to2);
    total++;
    if ({to1, to2} !== 2'b00 || rd_q.size() !== 256 || addr_log.size() !== 256) begin
      bad++; $display("FAIL maxlen_counts: to %b beats %0d reqs %0d want 00 256 256",
        {to1, to2}, rd_q.size(), addr_log.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        if (rd_q[i] !== mem_word(32'h1000 + 32'(4 * i)) || addr_log[i] !== 32'h1000 + 32'(4 * i)) data_bad++;
        if (rl_q[i]) last_cnt++;
      end
      total++;
      if (data_bad !== 0) begin bad++; $display("FAIL maxlen_data: wrong beats %0d want 0", data_bad); end
      total++;
      if (last_cnt !== 1 || rl_q[255] !== 1'b1 || addr_log[255] !== 32'h13FC) begin
        bad++; $display("FAIL maxlen_last: rlast count %0d final %b last addr %h want 1 1 000013fc",
          last_cnt, rl_q[255], addr_log[255]);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    arst_n = 1'b0; cke = 1'b1;
    ready_delay = 0; valid_cycles = 0; hold_err = 0;
    bus.axi_araddr_i  = 32'h0;
    bus.axi_arvalid_i = 1'b0;
    bus.axi_arid_i    = 1'b0;
    bus.axi_arlen_i   = 8'h0;
    bus.axi_arburst_i = 2'b00;
    bus.axi_rready_i  = 1'b0;
    test_reset();
    test_incr();
    test_fixed();
    test_wrap_err();
    test_addr_wrap();
    test_stall();
    test_cke();
    test_reset_mid_burst();
    test_max_len();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
